// File: rtl/thumb_cmd_encoder_if.sv
// Request and command handshake bundle for thumb_cmd_encoder.
// The slave modport is the encoder's view; master is the loader/core side.
interface thumb_cmd_encoder_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [2:0]  req_rd;
   logic [2:0]  req_rn;
   logic [2:0]  req_rm;
   logic [4:0]  req_imm;
   logic [15:0] cmd;
   logic        cmd_valid;
   logic        cmd_ready;

   modport slave (
      input  req_valid, req_op, req_rd, req_rn, req_rm, req_imm, cmd_ready,
      output req_ready, cmd, cmd_valid
   );

   modport master (
      output req_valid, req_op, req_rd, req_rn, req_rm, req_imm, cmd_ready,
      input  req_ready, cmd, cmd_valid
   );
endinterface

// File: rtl/thumb_cmd_encoder.sv
// Encodes decoded shift/add/sub requests into 16-bit Thumb words and queues them for the core.
// Optional macro VCPU_ENC_NOP_FILL_EN: present MOV r8,r8 (0x46C0) on cmd while empty instead of 0x0000.
module thumb_cmd_encoder #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic                sck,
   input  logic                rst_n,
   thumb_cmd_encoder_if.slave  bus,
   output logic [AW:0]         level,
   output logic                err,
   output logic [7:0]          err_cnt
);

`ifdef VCPU_ENC_NOP_FILL_EN
   localparam logic [15:0] FILL_WORD = 16'h46C0;
`else
   localparam logic [15:0] FILL_WORD = 16'h0000;
`endif

   logic [15:0] mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW-1:0] rd_ptr_next;
   logic [AW:0]   level_reg, level_next;
   logic [15:0]   cmd_reg, cmd_next;
   logic          err_reg;
   logic [7:0]    err_cnt_reg;

   logic [15:0] enc_word;
   logic        illegal;
   logic        full, empty, accept, push, pop;

   always_comb begin
      enc_word = 16'h0000;
      illegal  = 1'b0;
      case (bus.req_op)
         3'd0, 3'd1, 3'd2:
            enc_word = {3'b000, bus.req_op[1:0], bus.req_imm, bus.req_rm, bus.req_rd};
         3'd3, 3'd4:
            enc_word = {6'b000110, bus.req_op == 3'd4, bus.req_rm, bus.req_rn, bus.req_rd};
         3'd5, 3'd6: begin
            enc_word = {6'b000111, bus.req_op == 3'd6, bus.req_imm[2:0], bus.req_rn, bus.req_rd};
            illegal  = |bus.req_imm[4:3];
         end
         default: illegal = 1'b1;
      endcase
   end

   assign full   = (level_reg == (AW+1)'(DEPTH));
   assign empty  = (level_reg == '0);
   assign accept = bus.req_valid && !full;
   assign push   = accept && !illegal;
   assign pop    = bus.cmd_ready && !empty;

   // The pushed word becomes the head whenever it is the only entry left after this edge.
   always_comb begin
      level_next  = level_reg + (AW+1)'(push) - (AW+1)'(pop);
      rd_ptr_next = rd_ptr_reg + AW'(pop);
      cmd_next    = FILL_WORD;
      if (level_next != '0) begin
         if (push && level_next == (AW+1)'(1))
            cmd_next = enc_word;
         else
            cmd_next = mem_reg[rd_ptr_next];
      end
   end

   always_ff @(posedge sck) begin
      if (push)
         mem_reg[wr_ptr_reg] <= enc_word;
   end

   always_ff @(posedge sck) begin
      if (!rst_n) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         level_reg   <= '0;
         cmd_reg     <= FILL_WORD;
         err_reg     <= 1'b0;
         err_cnt_reg <= 8'd0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         rd_ptr_reg <= rd_ptr_next;
         level_reg  <= level_next;
         cmd_reg    <= cmd_next;
         err_reg    <= accept && illegal;
         if (accept && illegal && err_cnt_reg != 8'hFF)
            err_cnt_reg <= err_cnt_reg + 8'd1;
      end
   end

   assign bus.req_ready = !full;
   assign bus.cmd       = cmd_reg;
   assign bus.cmd_valid = !empty;
   assign level         = level_reg;
   assign err           = err_reg;
   assign err_cnt       = err_cnt_reg;

endmodule

// File: tb/tb_thumb_cmd_encoder.sv
// Directed bench for thumb_cmd_encoder: reset, encoding, fill/full, streaming, illegal ops, mid-stream reset.
module tb_thumb_cmd_encoder;

`ifdef VCPU_ENC_NOP_FILL_EN
   localparam logic [15:0] FILL = 16'h46C0;
`else
   localparam logic [15:0] FILL = 16'h0000;
`endif

   logic       sck = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] level;
   logic       err;
   logic [7:0] err_cnt;
   int         errors = 0;
   int         checks = 0;

   thumb_cmd_encoder_if bus ();

   thumb_cmd_encoder #(.DEPTH(4), .AW(2)) dut (
      .sck     (sck),
      .rst_n   (rst_n),
      .bus     (bus),
      .level   (level),
      .err     (err),
      .err_cnt (err_cnt)
   );

   always #5 sck = ~sck;

   task automatic step();
      @(posedge sck);
      #1;
   endtask

   task automatic drive_req(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                            input logic [2:0] rm, input logic [4:0] imm);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_rd    = rd;
      bus.req_rn    = rn;
      bus.req_rm    = rm;
      bus.req_imm   = imm;
   endtask

   // Shift-immediate word built arithmetically from field positions.
   function automatic logic [15:0] shift_word(input int op, input int imm, input int rm, input int rd);
      return 16'((op * 2048) + (imm * 64) + (rm * 8) + rd);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
      checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got=%b exp=0", bus.cmd_valid); end
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (bus.cmd !== FILL) begin errors++; $display("FAIL reset_cmd got=%h exp=%h", bus.cmd, FILL); end
      $display("reset: level=%0d cmd_valid=%b cmd=%h", level, bus.cmd_valid, bus.cmd);
   endtask

   task automatic test_encode();
      logic [2:0]  op_t  [4] = '{3'd0, 3'd2, 3'd4, 3'd5};
      logic [2:0]  rd_t  [4] = '{3'd1, 3'd7, 3'd0, 3'd3};
      logic [2:0]  rn_t  [4] = '{3'd0, 3'd0, 3'd1, 3'd4};
      logic [2:0]  rm_t  [4] = '{3'd2, 3'd0, 3'd2, 3'd0};
      logic [4:0]  imm_t [4] = '{5'd3, 5'd31, 5'd0, 5'd5};
      logic [15:0] exp_t [4] = '{16'h00D1, 16'h17C7, 16'h1A88, 16'h1D63};
      bus.cmd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_req(op_t[i], rd_t[i], rn_t[i], rm_t[i], imm_t[i]);
         step();
         bus.req_valid = 1'b0;
         checks++; if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL enc%0d_valid got=%b exp=1", i, bus.cmd_valid); end
         checks++; if (bus.cmd !== exp_t[i]) begin errors++; $display("FAIL enc%0d_word got=%h exp=%h", i, bus.cmd, exp_t[i]); end
         checks++; if (level !== 3'd1) begin errors++; $display("FAIL enc%0d_level got=%0d exp=1", i, level); end
         bus.cmd_ready = 1'b1;
         step();
         bus.cmd_ready = 1'b0;
         checks++; if (level !== 3'd0 || bus.cmd !== FILL) begin errors++; $display("FAIL enc%0d_drain level=%0d cmd=%h exp level=0 cmd=%h", i, level, bus.cmd, FILL); end
         $display("encode: op=%0d word=%h", op_t[i], exp_t[i]);
      end
   endtask

   task automatic test_fill_full();
      logic [15:0] q [$];
      logic [15:0] w;
      bus.cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_req(3'd0, 3'(i), 3'd0, 3'(7 - i), 5'(i + 1));
         checks++; if (bus.req_ready !== (i < 4)) begin errors++; $display("FAIL full_ready%0d got=%b exp=%b", i, bus.req_ready, i < 4); end
         if (i < 4) q.push_back(shift_word(0, i + 1, 7 - i, i));
         step();
      end
      bus.req_valid = 1'b0;
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level got=%0d exp=4", level); end
      checks++; if (bus.cmd !== q[0]) begin errors++; $display("FAIL full_head_stable got=%h exp=%h", bus.cmd, q[0]); end
      // Popping while full must not open the request side.
      drive_req(3'd3, 3'd1, 3'd1, 3'd1, 5'd0);
      bus.cmd_ready = 1'b1;
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got=%b exp=0", bus.req_ready); end
      for (int k = 0; k < 4; k++) begin
         w = q.pop_front();
         checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== w) begin errors++; $display("FAIL drain%0d got=%h valid=%b exp=%h", k, bus.cmd, bus.cmd_valid, w); end
         $display("drain: k=%0d word=%h level=%0d", k, bus.cmd, level);
         step();
         bus.req_valid = 1'b0;
      end
      checks++; if (level !== 3'd0 || bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL drain_end level=%0d valid=%b exp 0/0", level, bus.cmd_valid); end
      // Ready while empty must not underflow.
      step();
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL empty_ready_level got=%0d exp=0", level); end
      bus.cmd_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] w;
      bus.cmd_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         drive_req(3'd1, 3'(k), 3'd0, 3'(~k), 5'(k + 9));
         w = shift_word(1, k + 9, 7 - (k % 8), k % 8);
         step();
         checks++; if (level !== 3'd1 || bus.cmd !== w) begin errors++; $display("FAIL stream%0d level=%0d cmd=%h exp level=1 cmd=%h", k, level, bus.cmd, w); end
         $display("stream: k=%0d word=%h", k, bus.cmd);
      end
      bus.req_valid = 1'b0;
      step();
      checks++; if (level !== 3'd0 || bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL stream_end level=%0d valid=%b", level, bus.cmd_valid); end
      bus.cmd_ready = 1'b0;
   endtask

   task automatic test_illegal();
      bus.cmd_ready = 1'b0;
      drive_req(3'd7, 3'd1, 3'd2, 3'd3, 5'd0);
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got=%b exp=1", bus.req_ready); end
      step();
      checks++; if (err !== 1'b1 || err_cnt !== 8'd1 || level !== 3'd0) begin errors++; $display("FAIL ill_op7 err=%b cnt=%0d level=%0d exp 1/1/0", err, err_cnt, level); end
      drive_req(3'd5, 3'd1, 3'd2, 3'd0, 5'd8);
      step();
      checks++; if (err !== 1'b1 || err_cnt !== 8'd2 || level !== 3'd0) begin errors++; $display("FAIL ill_imm err=%b cnt=%0d level=%0d exp 1/2/0", err, err_cnt, level); end
      bus.req_valid = 1'b0;
      step();
      checks++; if (err !== 1'b0 || err_cnt !== 8'd2) begin errors++; $display("FAIL ill_pulse err=%b cnt=%0d exp 0/2", err, err_cnt); end
      $display("illegal: err_cnt=%0d", err_cnt);
      drive_req(3'd7, 3'd0, 3'd0, 3'd0, 5'd0);
      for (int k = 0; k < 258; k++) step();
      bus.req_valid = 1'b0;
      checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL ill_sat got=%0d exp=255", err_cnt); end
      $display("illegal: saturated err_cnt=%0d", err_cnt);
      step();
   endtask

   task automatic test_reset_mid();
      bus.cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_req(3'd3, 3'(i), 3'd2, 3'd5, 5'd0);
         step();
      end
      checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_level_pre got=%0d exp=3", level); end
      drive_req(3'd0, 3'd6, 3'd0, 3'd6, 5'd6);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      bus.req_valid = 1'b0;
      checks++; if (level !== 3'd0 || bus.cmd_valid !== 1'b0 || bus.cmd !== FILL) begin errors++; $display("FAIL mid_reset level=%0d valid=%b cmd=%h", level, bus.cmd_valid, bus.cmd); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_err_cnt got=%0d exp=0", err_cnt); end
      drive_req(3'd6, 3'd2, 3'd3, 3'd0, 5'd1);
      step();
      bus.req_valid = 1'b0;
      checks++; if (level !== 3'd1 || bus.cmd !== 16'h1E5A) begin errors++; $display("FAIL mid_next level=%0d cmd=%h exp 1/1e5a", level, bus.cmd); end
      bus.cmd_ready = 1'b1;
      step();
      bus.cmd_ready = 1'b0;
      checks++; if (level !== 3'd0 || bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_alone level=%0d valid=%b", level, bus.cmd_valid); end
      $display("reset_mid: single word drained");
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_rd    = 3'd0;
      bus.req_rn    = 3'd0;
      bus.req_rm    = 3'd0;
      bus.req_imm   = 5'd0;
      bus.cmd_ready = 1'b0;
      test_reset();
      test_encode();
      test_fill_full();
      test_back_to_back();
      test_illegal();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
